// File: rtl/clken_nco_pkg.sv
// Shared types and constants for the clken_nco_gen clock-enable generator:
// FSM state encoding, settle counter width and channel-index width.
package clken_nco_pkg;

  localparam int SETTLE_CNT_W = 16;
  localparam int CH_IDX_W     = 4;

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_SETTLE = 2'd1,
    S_LOCKED = 2'd2
  } nco_state_e;

  typedef logic [SETTLE_CNT_W-1:0] settle_cnt_t;
  typedef logic [CH_IDX_W-1:0]     ch_idx_t;

  // True when a configuration channel index addresses an existing channel.
  function automatic logic ch_in_range(input ch_idx_t ch, input int num_ch);
    int idx;
    idx = 32'(ch);
    return (idx < num_ch);
  endfunction

endpackage

// File: rtl/clken_nco_ch.sv
// clken_nco_ch: one NCO channel -- phase accumulator, increment register and registered carry.
// With CLKEN_NCO_SQUARE_OUT_EN defined it also provides a registered accumulator-MSB square output.
module clken_nco_ch
  import clken_nco_pkg::*;
#(
  parameter int               ACC_W   = 24,
  parameter logic [ACC_W-1:0] DEF_INC = '0
) (
  input  logic             refclk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [ACC_W-1:0] wr_inc,
  input  logic             sync,
`ifdef CLKEN_NCO_SQUARE_OUT_EN
  output logic             sq_out,
`endif
  output logic             clk_en
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W-1:0] inc_q;
  logic [ACC_W-1:0] inc_d;
  logic             clk_en_q;
  logic             clk_en_d;
  logic [ACC_W:0]   sum;

  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, inc_q};
    inc_d = wr_en ? wr_inc : inc_q;
    if (sync) begin
      // The add of the sync cycle is thrown away, including its carry.
      acc_d    = '0;
      clk_en_d = 1'b0;
    end else begin
      acc_d    = sum[ACC_W-1:0];
      clk_en_d = sum[ACC_W];
    end
  end

  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q    <= '0;
      inc_q    <= DEF_INC;
      clk_en_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      inc_q    <= inc_d;
      clk_en_q <= clk_en_d;
    end
  end

  assign clk_en = clk_en_q;

`ifdef CLKEN_NCO_SQUARE_OUT_EN
  logic sq_q;
  logic sq_d;

  // acc_d is already zero during sync, so the square output follows it to 0.
  always_comb begin
    sq_d = acc_d[ACC_W-1];
  end

  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      sq_q <= 1'b0;
    end else begin
      sq_q <= sq_d;
    end
  end

  assign sq_out = sq_q;
`else
  // No square output: the accumulator MSB only feeds the adder.
`endif

endmodule

// File: rtl/clken_nco_gen.sv
// clken_nco_gen: NUM_CH phase-accumulator clock-enable generators on refclk with a config
// handshake and lock tracking. Define CLKEN_NCO_SQUARE_OUT_EN to add the sq_out square-wave port.
module clken_nco_gen
  import clken_nco_pkg::*;
#(
  parameter int               NUM_CH        = 4,
  parameter int               ACC_W         = 24,
  parameter logic [ACC_W-1:0] DEF_INC       = '0,
  parameter int               SETTLE_CYCLES = 256
) (
  input  logic                refclk,
  input  logic                reset_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_IDX_W-1:0] cfg_ch,
  input  logic [ACC_W-1:0]    cfg_inc,
  input  logic                cfg_sync,
  output logic [NUM_CH-1:0]   clk_en,
`ifdef CLKEN_NCO_SQUARE_OUT_EN
  output logic [NUM_CH-1:0]   sq_out,
`endif
  output logic                locked
);

  localparam settle_cnt_t SETTLE_LAST = settle_cnt_t'(SETTLE_CYCLES - 1);

  nco_state_e  state_q;
  nco_state_e  state_d;
  settle_cnt_t cnt_q;
  settle_cnt_t cnt_d;
  logic        locked_q;
  logic        locked_d;

  logic              wr_accept;
  logic              wr_hit;
  logic              relock;
  logic [NUM_CH-1:0] wr_en;

  assign cfg_ready = (state_q != S_INIT);
  assign locked    = locked_q;

  // Out-of-range channel writes complete the handshake but touch nothing.
  always_comb begin
    wr_accept = cfg_valid & cfg_ready;
    wr_hit    = wr_accept & ch_in_range(cfg_ch, NUM_CH);
    relock    = wr_hit | cfg_sync;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_INIT: begin
        state_d = S_SETTLE;
        cnt_d   = '0;
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_LOCKED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + settle_cnt_t'(1);
        end
      end
      S_LOCKED: begin
        state_d = S_LOCKED;
      end
      default: begin
        state_d = S_INIT;
        cnt_d   = '0;
      end
    endcase
    // A reconfiguration always wins, even in the last settle cycle.
    if (relock) begin
      state_d = S_SETTLE;
      cnt_d   = '0;
    end
    locked_d = (state_d == S_LOCKED);
  end

  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_INIT;
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign wr_en[gi] = wr_hit & (cfg_ch == CH_IDX_W'(gi));

      clken_nco_ch #(
        .ACC_W   (ACC_W),
        .DEF_INC (DEF_INC)
      ) u_ch (
        .refclk  (refclk),
        .reset_n (reset_n),
        .wr_en   (wr_en[gi]),
        .wr_inc  (cfg_inc),
        .sync    (cfg_sync),
`ifdef CLKEN_NCO_SQUARE_OUT_EN
        .sq_out  (sq_out[gi]),
`endif
        .clk_en  (clk_en[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_clken_nco_gen.sv
// Directed bench for clken_nco_gen (NUM_CH=4, ACC_W=24, SETTLE_CYCLES=16) with hand-computed
// pulse positions; sq_out checks are built only with CLKEN_NCO_SQUARE_OUT_EN.
module tb_clken_nco_gen;

  localparam int NUM_CH = 4;
  localparam int ACC_W  = 24;

  logic              refclk    = 1'b0;
  logic              reset_n   = 1'b1;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [3:0]        cfg_ch    = 4'd0;
  logic [ACC_W-1:0]  cfg_inc   = '0;
  logic              cfg_sync  = 1'b0;
  logic [NUM_CH-1:0] clk_en;
  logic              locked;
`ifdef CLKEN_NCO_SQUARE_OUT_EN
  logic [NUM_CH-1:0] sq_out;
`endif

  int n_chk = 0;
  int n_bad = 0;

  always #5 refclk = ~refclk;

  clken_nco_gen #(
    .NUM_CH        (NUM_CH),
    .ACC_W         (ACC_W),
    .DEF_INC       (24'h0),
    .SETTLE_CYCLES (16)
  ) dut (
    .refclk    (refclk),
    .reset_n   (reset_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_inc   (cfg_inc),
    .cfg_sync  (cfg_sync),
    .clk_en    (clk_en),
`ifdef CLKEN_NCO_SQUARE_OUT_EN
    .sq_out    (sq_out),
`endif
    .locked    (locked)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic cfg_wr(input logic [3:0] ch, input logic [ACC_W-1:0] inc, input logic sync);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_inc   = inc;
    cfg_sync  = sync;
    tick();
    cfg_valid = 1'b0;
    cfg_sync  = 1'b0;
    $display("wr ch=%0d inc=%06h sync=%0b", ch, inc, sync);
  endtask

  // Called just after an edge with reset asserted; releases it and follows the relock.
  task automatic release_and_settle(input string ph);
    logic [NUM_CH-1:0] seen;
    seen    = '0;
    reset_n = 1'b1;
    chk({ph, "_ready_init"}, 32'(cfg_ready), 32'd0);
    for (int k = 1; k <= 17; k++) begin
      tick();
      seen |= clk_en;
      if (k == 1) chk({ph, "_ready_up"}, 32'(cfg_ready), 32'd1);
      if (k >= 16) chk($sformatf("%s_locked_k%0d", ph, k), 32'(locked), (k == 17) ? 32'd1 : 32'd0);
    end
    chk({ph, "_silent_def_inc"}, 32'(seen), 32'd0);
  endtask

  initial begin
    logic [31:0] t0;
    logic [31:0] t1;
    // Pulse positions after sync: ch0 inc 3/16 at k=6,11,16,22; ch1 inc 5/16 at k=4,7,10,13,16,20,23.
    t0 = 32'h0041_0840;
    t1 = 32'h0091_2490;

    #1 reset_n = 1'b0;
    #1;
    chk("rst_clk_en", 32'(clk_en), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_ready",  32'(cfg_ready), 32'd0);
    tick();
    tick();
    release_and_settle("rst1");

    // ch0 at a quarter of refclk; only ch0 may pulse.
    cfg_wr(4'd0, 24'h400000, 1'b0);
    chk("wr0_locked_drop", 32'(locked), 32'd0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk($sformatf("quarter_clk_en_k%0d", k), 32'(clk_en), (k % 4 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("quarter_locked_k%0d", k), 32'(locked), (k >= 16) ? 32'd1 : 32'd0);
    end

    // A second write 10 cycles in pushes lock out to 16 cycles after it.
    cfg_wr(4'd2, 24'h0, 1'b0);
    for (int k = 1; k <= 9; k++) tick();
    cfg_wr(4'd3, 24'h0, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("rewr_locked_k%0d", k), 32'(locked), (k == 16) ? 32'd1 : 32'd0);
    end

    // A write landing in the last settle cycle keeps locked low.
    cfg_wr(4'd2, 24'h0, 1'b0);
    for (int k = 1; k <= 15; k++) tick();
    cfg_wr(4'd3, 24'h0, 1'b0);
    chk("final_cycle_locked", 32'(locked), 32'd0);
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("final_locked_k%0d", k), 32'(locked), (k == 16) ? 32'd1 : 32'd0);
    end

    // Two channels, then sync while locked; an out-of-range write lands at k=17.
    cfg_wr(4'd0, 24'h300000, 1'b0);
    cfg_wr(4'd1, 24'h500000, 1'b0);
    for (int k = 1; k <= 16; k++) tick();
    chk("pre_sync_locked", 32'(locked), 32'd1);
    cfg_sync = 1'b1;
    tick();
    cfg_sync = 1'b0;
    $display("sync");
    chk("sync_locked_drop", 32'(locked), 32'd0);
    chk("sync_clk_en",      32'(clk_en), 32'd0);
    for (int k = 1; k <= 23; k++) begin
      if (k == 17) begin
        cfg_valid = 1'b1;
        cfg_ch    = 4'd4;
        cfg_inc   = 24'h7FFFFF;
      end
      tick();
      if (k == 17) begin
        cfg_valid = 1'b0;
        $display("wr ch=4 inc=7fffff (out of range)");
      end
      chk($sformatf("sync_clk_en_k%0d", k), 32'(clk_en), {30'd0, t1[k], t0[k]});
      chk($sformatf("sync_locked_k%0d", k), 32'(locked), (k >= 16) ? 32'd1 : 32'd0);
      chk($sformatf("sync_ready_k%0d", k),  32'(cfg_ready), 32'd1);
    end

    // Asynchronous reset between edges while ch1 is pulsing.
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_clk_en", 32'(clk_en), 32'd0);
    chk("async_rst_locked", 32'(locked), 32'd0);
    chk("async_rst_ready",  32'(cfg_ready), 32'd0);
    tick();
    tick();
    release_and_settle("rst2");

    // Write plus sync together: ch0 restarts from zero with the new increment.
    cfg_wr(4'd0, 24'h300000, 1'b0);
    for (int k = 1; k <= 5; k++) tick();
    cfg_wr(4'd0, 24'h200000, 1'b1);
    chk("wrsync_clk_en", 32'(clk_en), 32'd0);
`ifdef CLKEN_NCO_SQUARE_OUT_EN
    chk("wrsync_sq", 32'(sq_out), 32'd0);
`endif
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("eighth_clk_en_k%0d", k), 32'(clk_en), (k % 8 == 0) ? 32'd1 : 32'd0);
`ifdef CLKEN_NCO_SQUARE_OUT_EN
      chk($sformatf("eighth_sq_k%0d", k), 32'(sq_out), ((k % 8) >= 4) ? 32'd1 : 32'd0);
`endif
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
